// File: rtl/disp_pkg.sv
// Shared seven-segment constants, slot types and the dark-digit rule for the
// display scanner.
package disp_pkg;

    localparam logic [7:0] SEG_0 = 8'hFC;
    localparam logic [7:0] SEG_1 = 8'h60;
    localparam logic [7:0] SEG_2 = 8'hDA;
    localparam logic [7:0] SEG_3 = 8'hF2;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'hB6;
    localparam logic [7:0] SEG_6 = 8'hBE;
    localparam logic [7:0] SEG_7 = 8'hE0;
    localparam logic [7:0] SEG_8 = 8'hFE;
    localparam logic [7:0] SEG_9 = 8'hF6;
    localparam logic [7:0] SEG_A = 8'hEE;
    localparam logic [7:0] SEG_B = 8'h3E;
    localparam logic [7:0] SEG_C = 8'h9C;
    localparam logic [7:0] SEG_D = 8'h7A;
    localparam logic [7:0] SEG_E = 8'h9E;
    localparam logic [7:0] SEG_F = 8'h8E;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam int         DP_BIT    = 0;

    // First digit index of each 4-digit group.
    localparam int RIGHT_FIRST = 0;
    localparam int LEFT_FIRST  = 4;

    typedef logic [1:0] slot_idx_t;

    typedef struct packed {
        logic [3:0] ena;
        logic [7:0] led;
    } group_out_t;

    function automatic logic digit_dark(input logic blank_b, input logic blink_b,
                                        input logic blink_phase);
        return blank_b | (blink_b & blink_phase);
    endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Display bundle between the phase controllers, the scanner and the board mux.
// Display data is level-sampled at scan ticks; there is no valid/ready handshake.
interface seg_scan_if;

    logic        en;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic [7:0]  blink;
    logic [7:0]  led_r;
    logic [3:0]  ena_r;
    logic [7:0]  led_l;
    logic [3:0]  ena_l;
    logic        frame_done;

    modport master (
        input  en, digits, dp, blank, blink,
        output led_r, ena_r, led_l, ena_l, frame_done
    );

    modport slave (
        output en, digits, dp, blank, blink,
        input  led_r, ena_r, led_l, ena_l, frame_done
    );

endinterface

// File: rtl/hex_to_seg.sv
// Combinational hex digit to a..g segment decode (active-high, a in MSB).
module hex_to_seg
    import disp_pkg::*;
(
    input  logic [3:0] value_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK[7:1];
        case (value_i)
            4'h0: seg_o = SEG_0[7:1];
            4'h1: seg_o = SEG_1[7:1];
            4'h2: seg_o = SEG_2[7:1];
            4'h3: seg_o = SEG_3[7:1];
            4'h4: seg_o = SEG_4[7:1];
            4'h5: seg_o = SEG_5[7:1];
            4'h6: seg_o = SEG_6[7:1];
            4'h7: seg_o = SEG_7[7:1];
            4'h8: seg_o = SEG_8[7:1];
            4'h9: seg_o = SEG_9[7:1];
            4'hA: seg_o = SEG_A[7:1];
            4'hB: seg_o = SEG_B[7:1];
            4'hC: seg_o = SEG_C[7:1];
            4'hD: seg_o = SEG_D[7:1];
            4'hE: seg_o = SEG_E[7:1];
            4'hF: seg_o = SEG_F[7:1];
            default: seg_o = SEG_BLANK[7:1];
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed scanner for the right and left 4-digit seven-segment groups,
// with per-digit decimal point, blanking and blinking.
module seg_scan
    import disp_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    seg_scan_if.master disp
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    slot_idx_t        idx_q, idx_d;
    group_out_t       right_q, right_d;
    group_out_t       left_q, left_d;
    logic             frame_done_q, frame_done_d;

    logic       tick;
    logic [2:0] right_sel, left_sel;
    logic [3:0] right_val, left_val;
    logic [6:0] right_seg, left_seg;
    group_out_t right_slot, left_slot;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            idx_q         <= '0;
            right_q       <= '0;
            left_q        <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            idx_q         <= idx_d;
            right_q       <= right_d;
            left_q        <= left_d;
            frame_done_q  <= frame_done_d;
        end
    end

    // Scan and blink timebases run regardless of en.
    always_comb begin
        tick          = (div_cnt_q == DIV_LAST);
        div_cnt_d     = tick ? '0 : div_cnt_q + DIV_W'(1);
        idx_d         = tick ? idx_q + 2'd1 : idx_q;
        blink_cnt_d   = (blink_cnt_q == BLK_LAST) ? '0 : blink_cnt_q + BLK_W'(1);
        blink_phase_d = (blink_cnt_q == BLK_LAST) ? ~blink_phase_q : blink_phase_q;
    end

    // The slot is built for the index being entered on this tick edge.
    always_comb begin
        right_sel = 3'(RIGHT_FIRST) + 3'(idx_d);
        left_sel  = 3'(LEFT_FIRST) + 3'(idx_d);
        right_val = disp.digits[{right_sel, 2'b00} +: 4];
        left_val  = disp.digits[{left_sel, 2'b00} +: 4];
    end

    hex_to_seg u_hex_right (
        .value_i (right_val),
        .seg_o   (right_seg)
    );

    hex_to_seg u_hex_left (
        .value_i (left_val),
        .seg_o   (left_seg)
    );

    always_comb begin
        right_slot             = '0;
        right_slot.led         = {right_seg, 1'b0};
        right_slot.led[DP_BIT] = disp.dp[right_sel];
        right_slot.ena         = 4'b0001 << idx_d;
        if (digit_dark(disp.blank[right_sel], disp.blink[right_sel], blink_phase_q)) begin
            right_slot.ena = '0;
            right_slot.led = SEG_BLANK;
        end

        left_slot             = '0;
        left_slot.led         = {left_seg, 1'b0};
        left_slot.led[DP_BIT] = disp.dp[left_sel];
        left_slot.ena         = 4'b0001 << idx_d;
        if (digit_dark(disp.blank[left_sel], disp.blink[left_sel], blink_phase_q)) begin
            left_slot.ena = '0;
            left_slot.led = SEG_BLANK;
        end
    end

    // Disable darkens on the very next edge; re-enable waits for a tick.
    always_comb begin
        right_d      = right_q;
        left_d       = left_q;
        frame_done_d = tick && (idx_q == 2'd3);
        if (!disp.en) begin
            right_d = '0;
            left_d  = '0;
        end else if (tick) begin
            right_d = right_slot;
            left_d  = left_slot;
        end
    end

    assign disp.led_r      = right_q.led;
    assign disp.ena_r      = right_q.ena;
    assign disp.led_l      = left_q.led;
    assign disp.ena_l      = left_q.ena;
    assign disp.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed and random checks of seg_scan with a short scan and blink period.
module tb_seg_scan;

    localparam int SD = 4;
    localparam int BD = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg_scan_if dif ();

    seg_scan #(
        .SCAN_DIV  (SD),
        .BLINK_DIV (BD)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .disp (dif)
    );

    // Edges seen since reset release; edge n is a tick when n % SD == 0.
    int cyc = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    logic [24:0] exp_q[$];
    logic [7:0]  hex_tab[16];
    int          errors = 0;
    int          checks = 0;
    logic [24:0] last_exp;

    function automatic logic [24:0] observed();
        return {dif.frame_done, dif.ena_r, dif.led_r, dif.ena_l, dif.led_l};
    endfunction

    // Expected {frame_done, ena_r, led_r, ena_l, led_l} right after tick edge n.
    function automatic logic [24:0] model(input int n, input logic en_v);
        int k, i, j;
        logic phase, fd;
        logic [3:0] er, el;
        logic [7:0] lr, ll;
        k     = (n / SD) % 4;
        i     = k;
        j     = k + 4;
        phase = logic'(((n - 1) / BD) % 2);
        fd    = (k == 0);
        er = 4'b0001 << k;
        el = 4'b0001 << k;
        lr = hex_tab[dif.digits[4*i +: 4]] | {7'b0, dif.dp[i]};
        ll = hex_tab[dif.digits[4*j +: 4]] | {7'b0, dif.dp[j]};
        if (dif.blank[i] | (dif.blink[i] & phase)) begin er = '0; lr = '0; end
        if (dif.blank[j] | (dif.blink[j] & phase)) begin el = '0; ll = '0; end
        if (!en_v) begin er = '0; lr = '0; el = '0; ll = '0; end
        return {fd, er, lr, el, ll};
    endfunction

    task automatic check(input string tag, input logic [24:0] obs, input logic [24:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next tick edge, predicting its slot before it happens.
    task automatic tick_check(input string tag);
        int guard;
        guard = 0;
        while (((cyc + 1) % SD) != 0 && guard < 4 * SD) begin
            @(posedge clk); #1;
            guard++;
        end
        exp_q.push_back(model(cyc + 1, dif.en));
        @(posedge clk); #1;
        last_exp = exp_q.pop_front();
        check(tag, observed(), last_exp);
    endtask

    initial begin
        hex_tab = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
        dif.en     = 1'b0;
        dif.digits = 32'h0;
        dif.dp     = 8'h00;
        dif.blank  = 8'h00;
        dif.blink  = 8'h00;

        // Reset holds everything dark.
        #12;
        check("reset_state", observed(), 25'h0);
        dif.digits = 32'h7654_3210;
        dif.en     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", observed(), 25'h0);

        // First slot lands at edge SD with idx 1.
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("pre_first_tick", observed(), 25'h0);
        tick_check("first_tick_model");
        check("first_tick_const", observed(), {1'b0, 4'b0010, 8'h60, 4'b0010, 8'hB6});
        tick_check("slot2");
        tick_check("slot3");
        tick_check("slot0_wrap");
        check("slot0_const", observed(), {1'b1, 4'b0001, 8'hFC, 4'b0001, 8'h66});
        @(posedge clk); #1;
        check("frame_done_one_cycle", observed(), {1'b0, last_exp[23:0]});

        // Decimal point on digit 0 only.
        dif.dp          = 8'h01;
        dif.digits[3:0] = 4'h8;
        for (int s = 0; s < 4; s++) tick_check("dp_scan");
        check("dp_slot0_const", observed(), {1'b1, 4'b0001, 8'hFF, 4'b0001, 8'h66});

        // Blanked leftmost digit.
        dif.dp    = 8'h00;
        dif.blank = 8'h80;
        for (int s = 0; s < 4; s++) tick_check("blank_scan");

        // Blinking digit 0 across both blink phases.
        dif.blank = 8'h00;
        dif.blink = 8'h01;
        for (int s = 0; s < 16; s++) tick_check("blink_scan");
        dif.blink = 8'h00;

        // en dropped mid-slot darkens on the next edge but frame_done keeps pulsing.
        for (int g = 0; g < SD && (cyc % SD) != 1; g++) begin
            @(posedge clk); #1;
        end
        dif.en = 1'b0;
        @(posedge clk); #1;
        check("en_off_next_edge", {1'b0, observed() & 25'h0FF_FFFF}, 25'h0);
        for (int s = 0; s < 4; s++) tick_check("en_off_scan");

        // en raised mid-slot stays dark until the following tick.
        for (int g = 0; g < SD && (cyc % SD) != 1; g++) begin
            @(posedge clk); #1;
        end
        dif.en = 1'b1;
        @(posedge clk); #1;
        check("en_on_wait", observed() & 25'h0FF_FFFF, 25'h0);
        tick_check("en_on_resume");

        // Async reset while slot 2 is displayed.
        for (int g = 0; g < 4 && ((cyc / SD) % 4) != 2; g++) tick_check("to_slot2");
        check("at_slot2_ena", {21'h0, dif.ena_r}, 25'h4);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", observed(), 25'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_wait", observed(), 25'h0);
        tick_check("post_reset_first");
        check("post_reset_const", observed(), {1'b0, 4'b0010, 8'h60, 4'b0010, 8'hB6});

        // Random content, masks changed between ticks.
        for (int s = 0; s < 12; s++) begin
            dif.digits = $urandom;
            dif.dp     = 8'($urandom_range(0, 255));
            dif.blank  = 8'($urandom_range(0, 255));
            dif.blink  = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            tick_check("random_scan");
        end

        check("queue_drained", 25'(exp_q.size()), 25'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Time-multiplexed driver for the two 4-digit seven-segment groups (right and left).
- Takes eight hex/BCD digit values plus per-digit decimal-point, blank and blink masks from the phase controllers (pre / wash / billing).
- Produces the one-hot `ena_r`/`ena_l` and segment `led_r`/`led_l` patterns that the top-level mux forwards to the board.
- It is the producing end of the led/ena display interface the top level consumes.

Parameters:
- SCAN_DIV, 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz).
- BLINK_DIV, 50000000, clk cycles per blink phase toggle (0.5 s on, 0.5 s off).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- en  in  1  display enable; 0 forces all outputs dark
- digits  in  32  eight 4-bit values; [3:0]=digit0 (rightmost, right group) … [31:28]=digit7 (leftmost, left group)
- dp  in  8  decimal point per digit, bit i = digit i
- blank  in  8  1 = digit i dark
- blink  in  8  1 = digit i dark during blink-off phase
- led_r  out  8  right-group segments, {a,b,c,d,e,f,g,dp}, active-high
- ena_r  out  4  right-group digit enable, one-hot active-high, bit k = digit k
- led_l  out  8  left-group segments, same encoding
- ena_l  out  4  left-group enable, bit k = digit k+4
- frame_done  out  1  one-cycle pulse when a full 4-slot scan completes

Behaviour:
- Reset (rst=0, async): div_cnt=0, idx=0, blink_cnt=0, blink_phase=0, led_r=led_l=0, ena_r=ena_l=0, frame_done=0.
- Divider: div_cnt counts 0..SCAN_DIV-1 and wraps. tick = (div_cnt==SCAN_DIV-1).
- On tick:
  - idx advances 0→1→2→3→0.
  - Outputs are recomputed for the new idx on the same edge.
  - The first tick after reset lands at cycle SCAN_DIV and selects idx=1.
- Outputs are registered and change only on tick edges or on an `en` change (see below).
- Slot computation for position k=idx, right digit i=k, left digit j=k+4:
  - ena_r = 1<<k unless digit i is dark; ena_l likewise for digit j.
  - led = hex_seg(value) | dp bit at led[0].
  - A dark digit drives ena bit 0 and led 0.
- Dark condition for digit n: `blank[n]` | (`blink[n]` & blink_phase).
- Inputs are sampled only at the tick edge. Changes between ticks take effect at the next slot that displays that digit; no glitch or partial update.
- Hex encoding, before dp: 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6, A=EE, b=3E, C=9C, d=7A, E=9E, F=8E.
- Blink: blink_cnt counts 0..BLINK_DIV-1; blink_phase toggles when it wraps. It is free-running and independent of `en`.
- en=0:
  - On the next clk edge all four outputs go to 0 and stay there.
  - div_cnt, idx and blink keep running.
  - frame_done still pulses.
- en 0→1: outputs stay 0 until the next tick, then resume normal slots.
- frame_done = 1 for exactly the tick cycle where idx wraps 3→0.
- Reset mid-scan returns everything to the reset values immediately. Scanning restarts from idx=0 with a full SCAN_DIV wait.
- Latency from an input change to display is at most 4·SCAN_DIV cycles.

Decomposition:
- Shared package (`disp_pkg`):
  - SEG_0..SEG_F constants
  - SEG_BLANK=8'h00
  - DP_BIT=0
  - digit index constants for right/left groups
- Sub-module `hex_to_seg`: purely combinational 4-bit value → 7-bit a..g. It is instantiated twice (right and left slot).

Test Plan (SCAN_DIV=4, BLINK_DIV=32):
- Reset release, digits=32'h76543210, en=1, masks 0:
  - cycle 4 → ena_r=0010, led_r=60, ena_l=0010, led_l=B6.
  - After 4 ticks, idx=0 gives ena_r=0001, led_r=FC, ena_l=0001, led_l=66, with frame_done high that cycle only.
- dp=8'h01, digit0=8 → at idx=0 slot led_r=FF; other slots have no dp bit.
- blank=8'h80 → slot 3 gives ena_l=0000, led_l=00; right group still shows digit3 (ena_r=1000).
- blink=8'h01 → digit0 slot shows FC with blink_phase=0 and ena_r=0000/led_r=00 with blink_phase=1; the phase toggles every 32 cycles.
- en dropped mid-slot → all outputs 0 on the next edge. en raised → outputs stay 0 until the next tick, then show the correct slot.
- Assert rst during slot 2 → outputs immediately 0, frame_done 0. After release the first update occurs at cycle 4 with idx=1.
